// File: rtl/fsmc_stream_fifo_regs_pkg.sv
// Shared constants for the FSMC stream FIFO register block.
// Holds the register address map and the STATUS bit positions used by the top
// level read mux and by anything that decodes STATUS.
package fsmc_stream_fifo_regs_pkg;

   // Register addresses
   localparam int unsigned ADR_TX_DATA = 0;
   localparam int unsigned ADR_RX_DATA = 1;
   localparam int unsigned ADR_STATUS  = 2;
   localparam int unsigned ADR_SCRATCH = 3;

   // STATUS bit indices
   localparam int unsigned ST_RX_NE   = 0;
   localparam int unsigned ST_TX_FULL = 1;
   localparam int unsigned ST_RX_OVF  = 2;

endpackage

// File: rtl/fsmc_stream_fifo_regs_sync_fifo.sv
// sync_fifo: single-clock FIFO with registered pointers and occupancy count.
// Ports:
//   clk, rst     clock, asynchronous active-high reset (pointers/count only)
//   push, din    push request and data; accepted when not full, or when full
//                and a pop happens on the same edge
//   pop          pop request; ignored while empty
//   full, empty  occupancy flags from the registered count
//   head         entry at the read pointer (stale when empty)
//   count        occupancy 0..DEPTH
// Storage is not reset.
module sync_fifo #(
   parameter int unsigned W     = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [W-1:0]             din,
   input  logic                     pop,
   output logic                     full,
   output logic                     empty,
   output logic [W-1:0]             head,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          do_push, do_pop;

   assign full  = (count_q == CW'(DEPTH));
   assign empty = (count_q == '0);
   assign head  = mem[rd_ptr_q];
   assign count = count_q;

   // A pop frees a slot in the same edge, so a full FIFO can still accept a push.
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      unique case ({do_push, do_pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr_q] <= din;
   end

endmodule

// File: rtl/fsmc_stream_fifo_regs.sv
// fsmc_stream_fifo_regs: register stage behind the FSMC bus slave bridging the
// bus to a TX byte stream (valid/ready out) and a non-stallable RX stream.
// Register map: 0 TX_DATA (W push / R 0), 1 RX_DATA (R head, read pops),
//               2 STATUS {rx_ovf, tx_full, rx_ne} (read clears rx_ovf), 3 SCRATCH.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   do_write, w_data         write strobe and data from the bus slave
//   do_read                  read strobe (drives pop / clear-on-read)
//   rw_adr                   register address
//   read_data                combinational read mux (pre-pop/pre-clear values)
//   out_valid/out_data/out_ready   TX stream
//   in_valid/in_data         RX stream (always accepted, overflow if full)
//   irq                      only with FSMC_FIFO_IRQ_EN: registered rx_ne | rx_ovf
module fsmc_stream_fifo_regs
   import fsmc_stream_fifo_regs_pkg::*;
#(
   parameter int unsigned DATW  = 3,
   parameter int unsigned ADRW  = 2,
   parameter int unsigned DEPTH = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            do_write,
   input  logic [DATW-1:0] w_data,
   input  logic [ADRW-1:0] rw_adr,
   input  logic            do_read,
   output logic [DATW-1:0] read_data,
   output logic            out_valid,
   output logic [DATW-1:0] out_data,
   input  logic            out_ready,
   input  logic            in_valid,
   input  logic [DATW-1:0] in_data
`ifdef FSMC_FIFO_IRQ_EN
   ,
   output logic            irq
`endif
);

   localparam int unsigned CW = $clog2(DEPTH) + 1;

   logic            hit_tx, hit_rx, hit_st, hit_scr;
   logic            tx_push;
   logic            tx_full, tx_empty;
   logic [DATW-1:0] tx_head;
   logic [CW-1:0]   tx_count;
   logic            rx_pop;
   logic            rx_full, rx_empty;
   logic [DATW-1:0] rx_head;
   logic [CW-1:0]   rx_count;
   logic            ovf_set;
   logic            ovf_q, ovf_d;
   logic [DATW-1:0] scratch_q, scratch_d;
   logic [DATW-1:0] status;

   // Full-width compare so upper address bits must be zero to hit.
   assign hit_tx  = (rw_adr == ADRW'(ADR_TX_DATA));
   assign hit_rx  = (rw_adr == ADRW'(ADR_RX_DATA));
   assign hit_st  = (rw_adr == ADRW'(ADR_STATUS));
   assign hit_scr = (rw_adr == ADRW'(ADR_SCRATCH));

   assign tx_push = do_write & hit_tx;
   assign rx_pop  = do_read & hit_rx & ~rx_empty;
   // A same-edge pop makes room, so only an unserved full FIFO overflows.
   assign ovf_set = in_valid & rx_full & ~rx_pop;

   sync_fifo #(
      .W     (DATW),
      .DEPTH (DEPTH)
   ) u_tx_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (tx_push),
      .din   (w_data),
      .pop   (out_ready),
      .full  (tx_full),
      .empty (tx_empty),
      .head  (tx_head),
      .count (tx_count)
   );

   sync_fifo #(
      .W     (DATW),
      .DEPTH (DEPTH)
   ) u_rx_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (in_valid),
      .din   (in_data),
      .pop   (rx_pop),
      .full  (rx_full),
      .empty (rx_empty),
      .head  (rx_head),
      .count (rx_count)
   );

   assign out_valid = ~tx_empty;
   assign out_data  = tx_head;

   always_comb begin
      status             = '0;
      status[ST_RX_NE]   = ~rx_empty;
      status[ST_TX_FULL] = tx_full;
      status[ST_RX_OVF]  = ovf_q;
   end

   always_comb begin
      read_data = '0;
      if (hit_rx)       read_data = rx_empty ? '0 : rx_head;
      else if (hit_st)  read_data = status;
      else if (hit_scr) read_data = scratch_q;
   end

   always_comb begin
      ovf_d     = ovf_q;
      scratch_d = scratch_q;
      // Set has priority over clear-on-read so no overflow event is lost.
      if (ovf_set)                ovf_d = 1'b1;
      else if (do_read && hit_st) ovf_d = 1'b0;
      if (do_write && hit_scr) scratch_d = w_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ovf_q     <= 1'b0;
         scratch_q <= '0;
      end else begin
         ovf_q     <= ovf_d;
         scratch_q <= scratch_d;
      end
   end

`ifdef FSMC_FIFO_IRQ_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) irq <= 1'b0;
      else     irq <= ~rx_empty | ovf_q;
   end
`endif

   tx_count_a: assert property (@(posedge clk) disable iff (rst)
      tx_full == (tx_count == CW'(DEPTH)));
   rx_count_a: assert property (@(posedge clk) disable iff (rst)
      rx_empty == (rx_count == '0));

endmodule

// File: doc/fsmc_stream_fifo_regs.md
Name: fsmc_stream_fifo_regs

Overview:
- Register-side stage directly downstream of the FSMC clocked bus slave. Consumes do_write / w_data / rw_adr / do_read and returns read_data.
- Bridges the bus to two byte-stream FIFOs:
  - TX: bus writes feed a valid/ready output stream (e.g. toward a UART transmitter).
  - RX: a non-stallable input stream (e.g. a UART receiver) is read back through the bus.
- Provides a status register with clear-on-read side effects. This is why do_read exists.

Parameters:
- DATW, 3, data width of bus and streams; must be >= 3.
- ADRW, 2, register address width; only addresses 0..3 are decoded, higher address bits must be 0 to hit.
- DEPTH, 4, entries per FIFO; power of two, >= 2.

Ports:
- clk  in  1  system clock (PLL clock)
- rst  in  1  asynchronous reset, active-high
- do_write  in  1  single-cycle write strobe from bus slave
- w_data  in  DATW  write data, valid with do_write
- rw_adr  in  ADRW  register address; valid during do_write/do_read and held afterwards
- do_read  in  1  single-cycle read strobe from bus slave
- read_data  out  DATW  combinational read mux of rw_adr
- out_valid  out  1  TX stream: head of TX FIFO valid
- out_data  out  DATW  TX stream data
- out_ready  in  1  TX stream consumer ready
- in_valid  in  1  RX stream strobe; in_ready is implied-1 (source cannot stall)
- in_data  in  DATW  RX stream data

Behaviour:
- Register map:
  - 0 = TX_DATA: write pushes; read returns 0.
  - 1 = RX_DATA: read returns head; do_read pops.
  - 2 = STATUS: read-only.
  - 3 = SCRATCH: read/write.
- STATUS bits:
  - bit0 = RX non-empty.
  - bit1 = TX full.
  - bit2 = RX overflow (sticky).
  - Remaining bits 0.
- read_data is combinational from rw_adr and current state. The bus slave latches it on the same edge that do_read is high, so it must reflect pre-pop/pre-clear values in that cycle.
- RX_DATA read timing:
  - read_data = RX head when non-empty, 0 when empty.
  - Pop happens at the clock edge where do_read=1 & rw_adr==1 & non-empty.
  - Empty read: no pop, no error.
- STATUS read: do_read=1 & rw_adr==2 clears the overflow bit at that edge. The read returns the pre-clear value.
- Overflow set vs. STATUS read-clear in the same cycle: set wins (bit stays 1).
- TX push: do_write=1 & rw_adr==0 & not full. Write while full: data dropped, no state change.
- TX pop: out_valid & out_ready at the edge.
- Simultaneous TX push and pop when full: push accepted, count unchanged.
- RX push: in_valid=1 at an edge with RX not full.
- Simultaneous RX push and pop when full: push accepted.
- RX overflow: in_valid while full and no simultaneous pop. Data dropped, overflow bit set.
- out_valid = TX non-empty; out_data = TX head. Both registered-state driven (no combinational path from inputs).
- Writes to addresses 1 and 2 are ignored. SCRATCH is written on do_write & rw_adr==3.
- Pointers wrap modulo DEPTH. Count range is 0..DEPTH (width clog2(DEPTH)+1).
- Latency:
  - Bus write to out_valid: 1 cycle.
  - in_valid to STATUS bit0: 1 cycle.
- Reset (async, any time including mid-transfer):
  - Both FIFOs emptied; out_valid=0; overflow=0; SCRATCH=0.
  - read_data follows from reset state (0 for addresses 0, 1, 3; STATUS=0b010 only if full, so 0).
  - FIFO storage contents are not reset.

Optional Feature:
- FSMC_FIFO_IRQ_EN:
  - Defined: adds output port irq (1 bit), registered, reset 0, = RX non-empty | overflow, updated every cycle.
  - Not defined: port absent, no extra logic.

Decomposition:
- Shared package/include holds register address constants (ADR_TX_DATA=0, ADR_RX_DATA=1, ADR_STATUS=2, ADR_SCRATCH=3) and STATUS bit indices (ST_RX_NE=0, ST_TX_FULL=1, ST_RX_OVF=2).
- One sub-module, sync_fifo (params W, DEPTH; push/pop/full/empty/head/count; async active-high reset), instantiated twice.

Test Plan:
- After reset, write 3'b101 then 3'b011 to adr0 with out_ready=0 -> out_valid=1, out_data=3'b101. Raise out_ready -> 101 then 011 delivered on consecutive edges, then out_valid=0.
- Five writes to adr0 with out_ready=0, DEPTH=4 -> STATUS reads 3'b010; fifth value never appears on out_data.
- in_valid with 3'b110 -> next cycle STATUS reads 3'b001. do_read at adr1 returns 3'b110 in that cycle. Next cycle STATUS reads 3'b000 and adr1 reads 0.
- Five in_valid pulses with no reads -> STATUS reads 3'b101. The status do_read returns 101; next read returns 001. Overflow re-set in the same cycle as the status read -> bit2 remains 1.
- Write 3'b111 to adr3, read back 111 -> assert rst mid-sequence with TX holding 2 entries -> immediately out_valid=0, STATUS=0, adr3 reads 0.
- With FSMC_FIFO_IRQ_EN defined: in_valid pulse -> irq=1 two edges later. Pop the entry -> irq returns to 0 one cycle after the FIFO empties.
